requant_stage: RTL and testbench

//  Per-channel int32 -> int8 requantizer sitting directly downstream of the bias adder.

---
 rtl/requant_stage_if.sv | 29 ++
 rtl/requant_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_requant_stage.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/requant_stage_if.sv
// Row-stream interface for the requantizer: biased accumulator row in, int8 row out.
// The upstream side (bias adder / bench) uses master, the requantizer uses slave.
interface requant_stage_if #(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
);
    localparam int AW = $clog2(SIZE);

    logic [SIZE-1:0][DATA_WIDTH-1:0] data_in;
    logic                            valid_i;
    logic [AW-1:0]                   valid_depth_i;
    logic                            is_init_data_i;

    logic [SIZE-1:0][OUT_WIDTH-1:0]  data_out;
    logic                            output_valid_o;
    logic [AW-1:0]                   valid_depth_o;
    logic                            is_init_data_o;

    modport master (
        output data_in, valid_i, valid_depth_i, is_init_data_i,
        input  data_out, output_valid_o, valid_depth_o, is_init_data_o
    );

    modport slave (
        input  data_in, valid_i, valid_depth_i, is_init_data_i,
        output data_out, output_valid_o, valid_depth_o, is_init_data_o
    );
endinterface

// File: rtl/requant_stage.sv
// Per-channel int32 -> int8 requantizer (TFLM MultiplyByQuantizedMultiplier + zp + clamp).
// Three register stages, no backpressure, double-buffered per-lane multiplier/shift.
module requant_stage #(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int BUS_WIDTH  = 32,
    localparam int AW        = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_quant_cfg,
    input  logic                 need_requant,
    input  logic [31:0]          out_zero_point,
    input  logic [OUT_WIDTH-1:0] act_min,
    input  logic [OUT_WIDTH-1:0] act_max,
    input  logic                 qp_wr_en,
    input  logic                 qp_wr_sel,
    input  logic [AW-1:0]        qp_wr_addr,
    input  logic [BUS_WIDTH-1:0] qp_data_in,
    requant_stage_if.slave       row_if
);

    typedef logic [SIZE-1:0][31:0]          word_row_t;
    typedef logic [SIZE-1:0][5:0]           shift_row_t;
    typedef logic [SIZE-1:0][OUT_WIDTH-1:0] out_row_t;

    localparam logic [31:0]          MULT_RST  = 32'h4000_0000;
    localparam logic [5:0]           SHIFT_RST = 6'd1;
    localparam logic [OUT_WIDTH-1:0] LO_RST    = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] HI_RST    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [63:0]   I32_MAX   = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0]   I32_MIN   = 64'shFFFF_FFFF_8000_0000;

    function automatic logic signed [31:0] sat32(input logic signed [63:0] w);
        if (w > I32_MAX) return 32'sh7FFF_FFFF;
        if (w < I32_MIN) return 32'sh8000_0000;
        return w[31:0];
    endfunction

    function automatic logic [4:0] left_amt(input logic [5:0] sh);
        return sh[5] ? 5'd0 : sh[4:0];
    endfunction

    function automatic logic [5:0] right_amt(input logic [5:0] sh);
        return sh[5] ? (~sh + 6'd1) : 6'd0;
    endfunction

    function automatic logic signed [31:0] shl_sat(input logic signed [31:0] x,
                                                   input logic [4:0] ls);
        logic signed [63:0] w;
        w = {{32{x[31]}}, x};
        return sat32(w <<< ls);
    endfunction

    // Saturating rounding doubling high multiply; the only overflow is MIN*MIN.
    function automatic logic signed [31:0] srdhm(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        logic signed [63:0] p;
        logic signed [63:0] s;
        if (a == 32'sh8000_0000 && b == 32'sh8000_0000) return 32'sh7FFF_FFFF;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        s = p + (p[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000);
        s = s + (s[63] ? 64'sh0000_0000_7FFF_FFFF : 64'sh0);
        s = s >>> 31;
        return s[31:0];
    endfunction

    function automatic logic signed [31:0] rdbpot(input logic signed [31:0] v,
                                                  input logic [5:0] rs);
        logic signed [63:0] w;
        logic [63:0]        mask;
        logic [63:0]        rem;
        logic [63:0]        thr;
        w    = {{32{v[31]}}, v};
        mask = (64'd1 << rs) - 64'd1;
        rem  = w & mask;
        thr  = (mask >> 1) + {63'd0, v[31]};
        w    = (w >>> rs) + ((rem > thr) ? 64'sd1 : 64'sd0);
        return w[31:0];
    endfunction

    function automatic logic signed [31:0] add_sat(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        return sat32($signed({{32{a[31]}}, a}) + $signed({{32{b[31]}}, b}));
    endfunction

    // Max bound applied last so an inverted range resolves to act_max.
    function automatic logic [OUT_WIDTH-1:0] clamp(input logic signed [31:0] y,
                                                   input logic [OUT_WIDTH-1:0] lo,
                                                   input logic [OUT_WIDTH-1:0] hi);
        logic signed [31:0] lo_w;
        logic signed [31:0] hi_w;
        logic signed [31:0] r;
        lo_w = {{(32-OUT_WIDTH){lo[OUT_WIDTH-1]}}, lo};
        hi_w = {{(32-OUT_WIDTH){hi[OUT_WIDTH-1]}}, hi};
        r = y;
        if (r < lo_w) r = lo_w;
        if (r > hi_w) r = hi_w;
        return r[OUT_WIDTH-1:0];
    endfunction

    word_row_t             shd_mult_q, shd_mult_d, act_mult_q, act_mult_d;
    shift_row_t            shd_shift_q, shd_shift_d, act_shift_q, act_shift_d;
    logic                  act_need_q, act_need_d;
    logic [31:0]           act_zp_q, act_zp_d;
    logic [OUT_WIDTH-1:0]  act_lo_q, act_lo_d, act_hi_q, act_hi_d;

    logic                  s1_valid_q, s1_valid_d, s1_init_q, s1_init_d;
    logic [AW-1:0]         s1_depth_q, s1_depth_d;
    word_row_t             s1_x_q, s1_x_d, s1_m_q, s1_m_d;
    shift_row_t            s1_rs_q, s1_rs_d;
    logic                  s1_need_q, s1_need_d;
    logic [31:0]           s1_zp_q, s1_zp_d;
    logic [OUT_WIDTH-1:0]  s1_lo_q, s1_lo_d, s1_hi_q, s1_hi_d;

    logic                  s2_valid_q, s2_valid_d, s2_init_q, s2_init_d;
    logic [AW-1:0]         s2_depth_q, s2_depth_d;
    word_row_t             s2_v_q, s2_v_d;
    shift_row_t            s2_rs_q, s2_rs_d;
    logic                  s2_need_q, s2_need_d;
    logic [31:0]           s2_zp_q, s2_zp_d;
    logic [OUT_WIDTH-1:0]  s2_lo_q, s2_lo_d, s2_hi_q, s2_hi_d;

    logic                  out_valid_q, out_valid_d, out_init_q, out_init_d;
    logic [AW-1:0]         out_depth_q, out_depth_d;
    out_row_t              out_data_q, out_data_d;

    always_comb begin
        shd_mult_d  = shd_mult_q;
        shd_shift_d = shd_shift_q;
        act_mult_d  = act_mult_q;
        act_shift_d = act_shift_q;
        act_need_d  = act_need_q;
        act_zp_d    = act_zp_q;
        act_lo_d    = act_lo_q;
        act_hi_d    = act_hi_q;
        s1_x_d = s1_x_q;  s1_m_d = s1_m_q;  s1_rs_d = s1_rs_q;  s1_need_d = s1_need_q;
        s1_zp_d = s1_zp_q; s1_lo_d = s1_lo_q; s1_hi_d = s1_hi_q;
        s2_v_d = s2_v_q;  s2_rs_d = s2_rs_q; s2_need_d = s2_need_q;
        s2_zp_d = s2_zp_q; s2_lo_d = s2_lo_q; s2_hi_d = s2_hi_q;
        out_data_d = out_data_q;

        if (qp_wr_en) begin
            if (qp_wr_sel) shd_shift_d[qp_wr_addr] = qp_data_in[5:0];
            else           shd_mult_d[qp_wr_addr]  = qp_data_in[31:0];
        end
        // Promoting from the _d copy merges a write landing in the same cycle.
        if (init_quant_cfg) begin
            act_mult_d  = shd_mult_d;
            act_shift_d = shd_shift_d;
            act_need_d  = need_requant;
            act_zp_d    = out_zero_point;
            act_lo_d    = act_min;
            act_hi_d    = act_max;
        end

        s1_valid_d = row_if.valid_i;
        s1_depth_d = row_if.valid_depth_i;
        s1_init_d  = row_if.is_init_data_i;
        if (row_if.valid_i) begin
            for (int i = 0; i < SIZE; i++) begin
                s1_x_d[i]  = act_need_q ? shl_sat(row_if.data_in[i], left_amt(act_shift_q[i]))
                                        : row_if.data_in[i];
                s1_m_d[i]  = act_mult_q[i];
                s1_rs_d[i] = right_amt(act_shift_q[i]);
            end
            s1_need_d = act_need_q;
            s1_zp_d   = act_zp_q;
            s1_lo_d   = act_lo_q;
            s1_hi_d   = act_hi_q;
        end

        s2_valid_d = s1_valid_q;
        s2_depth_d = s1_depth_q;
        s2_init_d  = s1_init_q;
        if (s1_valid_q) begin
            for (int i = 0; i < SIZE; i++) begin
                s2_v_d[i] = s1_need_q ? srdhm(s1_x_q[i], s1_m_q[i]) : s1_x_q[i];
            end
            s2_rs_d   = s1_rs_q;
            s2_need_d = s1_need_q;
            s2_zp_d   = s1_zp_q;
            s2_lo_d   = s1_lo_q;
            s2_hi_d   = s1_hi_q;
        end

        out_valid_d = s2_valid_q;
        out_depth_d = s2_depth_q;
        out_init_d  = s2_init_q;
        if (s2_valid_q) begin
            for (int i = 0; i < SIZE; i++) begin
                out_data_d[i] = clamp(add_sat(s2_need_q ? rdbpot(s2_v_q[i], s2_rs_q[i]) : s2_v_q[i],
                                              s2_zp_q), s2_lo_q, s2_hi_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_mult_q  <= {SIZE{MULT_RST}};
            shd_shift_q <= {SIZE{SHIFT_RST}};
            act_mult_q  <= {SIZE{MULT_RST}};
            act_shift_q <= {SIZE{SHIFT_RST}};
            act_need_q  <= 1'b1;
            act_zp_q    <= '0;
            act_lo_q    <= LO_RST;
            act_hi_q    <= HI_RST;
            s1_valid_q <= 1'b0; s1_depth_q <= '0; s1_init_q <= 1'b0;
            s1_x_q <= '0; s1_m_q <= '0; s1_rs_q <= '0; s1_need_q <= 1'b0;
            s1_zp_q <= '0; s1_lo_q <= '0; s1_hi_q <= '0;
            s2_valid_q <= 1'b0; s2_depth_q <= '0; s2_init_q <= 1'b0;
            s2_v_q <= '0; s2_rs_q <= '0; s2_need_q <= 1'b0;
            s2_zp_q <= '0; s2_lo_q <= '0; s2_hi_q <= '0;
            out_valid_q <= 1'b0; out_depth_q <= '0; out_init_q <= 1'b0; out_data_q <= '0;
        end else begin
            shd_mult_q  <= shd_mult_d;
            shd_shift_q <= shd_shift_d;
            act_mult_q  <= act_mult_d;
            act_shift_q <= act_shift_d;
            act_need_q  <= act_need_d;
            act_zp_q    <= act_zp_d;
            act_lo_q    <= act_lo_d;
            act_hi_q    <= act_hi_d;
            s1_valid_q <= s1_valid_d; s1_depth_q <= s1_depth_d; s1_init_q <= s1_init_d;
            s1_x_q <= s1_x_d; s1_m_q <= s1_m_d; s1_rs_q <= s1_rs_d; s1_need_q <= s1_need_d;
            s1_zp_q <= s1_zp_d; s1_lo_q <= s1_lo_d; s1_hi_q <= s1_hi_d;
            s2_valid_q <= s2_valid_d; s2_depth_q <= s2_depth_d; s2_init_q <= s2_init_d;
            s2_v_q <= s2_v_d; s2_rs_q <= s2_rs_d; s2_need_q <= s2_need_d;
            s2_zp_q <= s2_zp_d; s2_lo_q <= s2_lo_d; s2_hi_q <= s2_hi_d;
            out_valid_q <= out_valid_d; out_depth_q <= out_depth_d;
            out_init_q <= out_init_d; out_data_q <= out_data_d;
        end
    end

    assign row_if.data_out       = out_data_q;
    assign row_if.output_valid_o = out_valid_q;
    assign row_if.valid_depth_o  = out_depth_q;
    assign row_if.is_init_data_o = out_init_q;

endmodule

// File: tb/tb_requant_stage.sv
// Bench for requant_stage: arithmetic reference model compared every cycle, plus
// directed rows whose lane-0 results are pinned to hand-computed values.
module tb_requant_stage;

    typedef logic [15:0][7:0] row8_t;

    localparam longint I32_MAX = 64'sd2147483647;
    localparam longint I32_MIN = -64'sd2147483648;

    logic        clk;
    logic        rst_n;
    logic        init_quant_cfg;
    logic        need_requant;
    logic [31:0] out_zero_point;
    logic [7:0]  act_min;
    logic [7:0]  act_max;
    logic        qp_wr_en;
    logic        qp_wr_sel;
    logic [3:0]  qp_wr_addr;
    logic [31:0] qp_data_in;

    int checks_total  = 0;
    int checks_passed = 0;
    int row_cnt       = 0;

    requant_stage_if #(.SIZE(16), .DATA_WIDTH(32), .OUT_WIDTH(8)) rif ();

    requant_stage #(.SIZE(16), .DATA_WIDTH(32), .OUT_WIDTH(8), .BUS_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_quant_cfg (init_quant_cfg),
        .need_requant   (need_requant),
        .out_zero_point (out_zero_point),
        .act_min        (act_min),
        .act_max        (act_max),
        .qp_wr_en       (qp_wr_en),
        .qp_wr_sel      (qp_wr_sel),
        .qp_wr_addr     (qp_wr_addr),
        .qp_data_in     (qp_data_in),
        .row_if         (rif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_int(input string name, input longint got, input longint exp);
        checks_total++;
        if (got == exp) checks_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference arithmetic on 64-bit integers, straight from the requantization rules.
    function automatic longint sat(input longint v);
        if (v > I32_MAX) return I32_MAX;
        if (v < I32_MIN) return I32_MIN;
        return v;
    endfunction

    function automatic int model_lane(input int x, input int m, input int sh, input bit nr,
                                      input int zp, input int lo, input int hi);
        longint v, p, nudge, d, q, r;
        v = x;
        if (nr) begin
            if (sh > 0) v = sat(v * (longint'(1) << sh));
            if (v == I32_MIN && longint'(m) == I32_MIN) v = I32_MAX;
            else begin
                p = v * m;
                nudge = (p >= 0) ? (longint'(1) << 30) : (longint'(1) - (longint'(1) << 30));
                v = (p + nudge) / (longint'(1) << 31);
            end
            if (sh < 0) begin
                d = longint'(1) << (-sh);
                q = v / d;
                r = v % d;
                if (r < 0) r = -r;
                if (2 * r >= d) q = q + ((v < 0) ? -1 : 1);
                v = q;
            end
        end
        v = sat(v + zp);
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return int'(v);
    endfunction

    int    sh_mult[16], sh_shift[16], a_mult[16], a_shift[16];
    bit    a_need;
    int    a_zp, a_lo, a_hi;
    logic  pv[3];
    row8_t pd[3];
    logic [3:0] pdep[3];
    logic  pinit[3];
    row8_t exp_last;

    function automatic row8_t model_row();
        row8_t r;
        int x, y;
        for (int i = 0; i < 16; i++) begin
            x = $signed(rif.data_in[i]);
            y = model_lane(x, a_mult[i], a_shift[i], a_need, a_zp, a_lo, a_hi);
            r[i] = y[7:0];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                sh_mult[i] <= 32'h4000_0000; sh_shift[i] <= 1;
                a_mult[i]  <= 32'h4000_0000; a_shift[i]  <= 1;
            end
            a_need <= 1'b1; a_zp <= 0; a_lo <= -128; a_hi <= 127;
            for (int k = 0; k < 3; k++) begin
                pv[k] <= 1'b0; pd[k] <= '0; pdep[k] <= '0; pinit[k] <= 1'b0;
            end
            exp_last <= '0;
        end else begin
            pv[0] <= rif.valid_i;        pv[1] <= pv[0];     pv[2] <= pv[1];
            pd[0] <= model_row();        pd[1] <= pd[0];     pd[2] <= pd[1];
            pdep[0] <= rif.valid_depth_i; pdep[1] <= pdep[0]; pdep[2] <= pdep[1];
            pinit[0] <= rif.is_init_data_i; pinit[1] <= pinit[0]; pinit[2] <= pinit[1];
            if (pv[1]) exp_last <= pd[1];
            if (qp_wr_en) begin
                if (qp_wr_sel) sh_shift[qp_wr_addr] <= int'($signed(qp_data_in[5:0]));
                else           sh_mult[qp_wr_addr]  <= int'($signed(qp_data_in));
            end
            if (init_quant_cfg) begin
                for (int i = 0; i < 16; i++) begin
                    a_mult[i]  <= (qp_wr_en && !qp_wr_sel && qp_wr_addr == 4'(i))
                                  ? int'($signed(qp_data_in)) : sh_mult[i];
                    a_shift[i] <= (qp_wr_en && qp_wr_sel && qp_wr_addr == 4'(i))
                                  ? int'($signed(qp_data_in[5:0])) : sh_shift[i];
                end
                a_need <= need_requant;
                a_zp   <= int'($signed(out_zero_point));
                a_lo   <= int'($signed(act_min));
                a_hi   <= int'($signed(act_max));
            end
        end
    end

    always @(negedge clk) begin
        check_int("out_valid", rif.output_valid_o, pv[2]);
        check_int("out_depth", rif.valid_depth_o, pdep[2]);
        check_int("out_is_init", rif.is_init_data_o, pinit[2]);
        check_vec("out_data", rif.data_out, exp_last);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int x, input int step);
        for (int i = 0; i < 16; i++) rif.data_in[i] = 32'(x + i * step);
        rif.valid_i        = 1'b1;
        rif.valid_depth_i  = 4'(row_cnt);
        rif.is_init_data_i = row_cnt[0];
        row_cnt++;
    endtask

    task automatic clear_row();
        rif.valid_i        = 1'b0;
        rif.valid_depth_i  = '0;
        rif.is_init_data_i = 1'b0;
    endtask

    task automatic wr(input bit sel, input int addr, input logic [31:0] data);
        qp_wr_en = 1'b1; qp_wr_sel = sel; qp_wr_addr = 4'(addr); qp_data_in = data;
        cycle();
        qp_wr_en = 1'b0;
    endtask

    task automatic set_cfg(input bit nr, input int zp, input int lo, input int hi);
        need_requant = nr; out_zero_point = 32'(zp); act_min = 8'(lo); act_max = 8'(hi);
        init_quant_cfg = 1'b1;
    endtask

    task automatic do_init(input bit nr, input int zp, input int lo, input int hi);
        set_cfg(nr, zp, lo, hi);
        cycle();
        init_quant_cfg = 1'b0;
    endtask

    task automatic send_check(input string name, input int x, input int step, input int exp0);
        set_row(x, step);
        cycle();
        clear_row();
        cycle();
        cycle();
        check_int({name, "_valid"}, rif.output_valid_o, 1);
        check_int({name, "_lane0"}, $signed(rif.data_out[0]), exp0);
    endtask

    initial begin
        rst_n = 1'b0;
        init_quant_cfg = 1'b0; need_requant = 1'b0; out_zero_point = '0;
        act_min = '0; act_max = '0;
        qp_wr_en = 1'b0; qp_wr_sel = 1'b0; qp_wr_addr = '0; qp_data_in = '0;
        rif.data_in = '0;
        clear_row();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check_int("reset_valid", rif.output_valid_o, 0);
        check_vec("reset_data", rif.data_out, '0);

        send_check("identity", 100, 0, 100);

        wr(0, 0, 32'h4000_0000);
        wr(1, 0, 32'h0000_0000);
        do_init(1, 3, -128, 127);
        send_check("half_zp_pos", 100, 0, 53);
        send_check("half_zp_neg", -101, 0, -47);

        wr(1, 0, 32'h0000_003E);
        do_init(1, 0, -128, 127);
        send_check("rshift_round", 100, 3, 13);
        send_check("rshift_exact", 1000, 3, 125);
        send_check("rshift_clamp", 2000, 3, 127);

        wr(0, 0, 32'h8000_0000);
        wr(1, 0, 32'h0000_0000);
        do_init(1, 0, -128, 127);
        send_check("srdhm_minmin", int'(32'h8000_0000), 0, 127);

        wr(0, 0, 32'h4000_0000);
        wr(1, 0, 32'h0000_0002);
        do_init(1, 0, -128, 127);
        send_check("lshift_sat", 32'h4000_0000, 0, 127);

        wr(1, 0, 32'h0000_0000);
        for (int k = 0; k < 8; k++) begin
            set_row(100 + 10 * k, 1);
            if (k == 4) begin
                set_cfg(1, 7, -128, 127);
                qp_wr_en = 1'b1; qp_wr_sel = 1'b0; qp_wr_addr = 4'd1; qp_data_in = 32'h2000_0000;
            end
            cycle();
            init_quant_cfg = 1'b0;
            qp_wr_en = 1'b0;
        end
        clear_row();
        cycle();
        cycle();
        cycle();

        wr(0, 0, 32'h1000_0000);
        send_check("shadow_only", 100, 0, 57);

        do_init(0, -5, -128, 127);
        send_check("bypass_zp", 50, 0, 45);
        send_check("bypass_clamp", -500, 0, -128);

        do_init(1, 0, 10, -10);
        send_check("inverted_clamp", 100, 0, -10);

        set_row(300, 2);
        cycle();
        set_row(-300, 2);
        cycle();
        clear_row();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_int("post_reset_valid", rif.output_valid_o, 0);
        end
        send_check("reset_params", 100, 0, 100);
        do_init(1, 0, -128, 127);
        send_check("reset_shadow", 100, 0, 100);

        cycle();
        cycle();
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
